// File: rtl/controle_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: FSM states,
// opcode/funct constants, ALU operations, mux selects and instruction classes.
package controle_pkg;

    typedef enum logic [4:0] {
        ST_RESET      = 5'd0,
        ST_FETCH      = 5'd1,
        ST_FETCH_WAIT = 5'd2,
        ST_DECODE     = 5'd3,
        ST_EXEC_R     = 5'd4,
        ST_EXEC_I     = 5'd5,
        ST_WB_ALU     = 5'd6,
        ST_ADDR       = 5'd7,
        ST_MEM_RD     = 5'd8,
        ST_MEM_WAIT   = 5'd9,
        ST_WB_LD      = 5'd10,
        ST_MEM_WR     = 5'd11,
        ST_BRANCH     = 5'd12,
        ST_WB_LUI     = 5'd13,
        ST_PC_INC     = 5'd14,
        ST_HALT       = 5'd15
    } state_t;

    typedef enum logic [2:0] {
        IC_R    = 3'd0,
        IC_ADDI = 3'd1,
        IC_LD   = 3'd2,
        IC_SD   = 3'd3,
        IC_BEQ  = 3'd4,
        IC_BNE  = 3'd5,
        IC_LUI  = 3'd6,
        IC_BAD  = 3'd7
    } instr_class_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_DW   = 3'b011;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    localparam logic       SRCA_PC    = 1'b0;
    localparam logic       SRCA_REGA  = 1'b1;
    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_SHIFT = 2'b11;
    localparam logic [2:0] WB_ALUOUT  = 3'b000;
    localparam logic [2:0] WB_MEMDATA = 3'b001;
    localparam logic [2:0] WB_IMM     = 3'b010;
    localparam logic       PC_ALU     = 1'b0;
    localparam logic       PC_ALUOUT  = 1'b1;

endpackage

// File: rtl/controle_multiciclo_decodifica_instr.sv
// Combinational instruction classifier: opcode/funct3/funct7 to class,
// R-type ALU operation and an illegal-encoding flag.
module decodifica_instr
    import controle_pkg::*;
(
    input  logic [6:0]   opcode,
    input  logic [2:0]   funct3,
    input  logic [6:0]   funct7,
    output instr_class_t iclass,
    output logic [2:0]   r_alu_op,
    output logic         illegal
);

    logic r_bad_s;

    // Classify the opcode and resolve the R-type function
    always_comb begin
        iclass   = IC_BAD;
        r_alu_op = ALU_ADD;
        r_bad_s  = 1'b0;

        case (opcode)
            OP_R:      iclass = IC_R;
            OP_IMM:    iclass = (funct3 == F3_ADD) ? IC_ADDI : IC_BAD;
            OP_LOAD:   iclass = (funct3 == F3_DW)  ? IC_LD   : IC_BAD;
            OP_STORE:  iclass = (funct3 == F3_DW)  ? IC_SD   : IC_BAD;
            OP_BRANCH: begin
                if (funct3 == F3_BEQ) begin
                    iclass = IC_BEQ;
                end else if (funct3 == F3_BNE) begin
                    iclass = IC_BNE;
                end else begin
                    iclass = IC_BAD;
                end
            end
            OP_LUI:    iclass = IC_LUI;
            default:   iclass = IC_BAD;
        endcase

        // and/slt ignore funct7; add/sub are told apart by it
        case (funct3)
            F3_ADD: begin
                if (funct7 == F7_BASE) begin
                    r_alu_op = ALU_ADD;
                end else if (funct7 == F7_SUB) begin
                    r_alu_op = ALU_SUB;
                end else begin
                    r_bad_s = 1'b1;
                end
            end
            F3_AND:  r_alu_op = ALU_AND;
            F3_SLT:  r_alu_op = ALU_SLT;
            default: r_bad_s  = 1'b1;
        endcase

        illegal = (iclass == IC_BAD) || ((iclass == IC_R) && r_bad_s);
    end

endmodule

// File: rtl/controle_multiciclo.sv
// Moore control FSM for the multicycle 64-bit RISC-V datapath; drives every
// mux select, register load and write strobe from the current state.
module controle_multiciclo
    import controle_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  i6_0,
    input  logic [31:0] i31_0,
    input  logic        AluZero,
    output logic        PCwrite,
    output logic        PCWriteCond,
    output logic        LoadIR,
    output logic        MemRead,
    output logic        MemData_Read,
    output logic        SelMux2,
    output logic [1:0]  SelMux4,
    output logic [2:0]  SelMuxMem,
    output logic        SelMuxPC,
    output logic        RegWrite,
    output logic        loadRegA,
    output logic        loadRegB,
    output logic        loadRegMemData,
    output logic        loadRegAluOut,
    output logic [2:0]  AluOperation,
    output logic        halted,
    output logic [4:0]  state_o
);

    state_t       state_q, state_d;
    instr_class_t iclass_s;
    logic [2:0]   r_alu_op_s;
    logic         illegal_s;
    logic         taken_s;
    logic         unused_ir_s;

    assign unused_ir_s = ^{i31_0[24:15], i31_0[11:0]};

    decodifica_instr u_dec (
        .opcode   (i6_0),
        .funct3   (i31_0[14:12]),
        .funct7   (i31_0[31:25]),
        .iclass   (iclass_s),
        .r_alu_op (r_alu_op_s),
        .illegal  (illegal_s)
    );

    // State register; reset forces RESET immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and state-decoded control outputs
    always_comb begin
        state_d        = state_q;
        taken_s        = 1'b0;
        PCwrite        = 1'b0;
        PCWriteCond    = 1'b0;
        LoadIR         = 1'b0;
        MemRead        = 1'b0;
        MemData_Read   = 1'b0;
        SelMux2        = SRCA_PC;
        SelMux4        = SRCB_REGB;
        SelMuxMem      = WB_ALUOUT;
        SelMuxPC       = PC_ALU;
        RegWrite       = 1'b0;
        loadRegA       = 1'b0;
        loadRegB       = 1'b0;
        loadRegMemData = 1'b0;
        loadRegAluOut  = 1'b0;
        AluOperation   = ALU_ADD;
        halted         = 1'b0;

        case (state_q)
            ST_RESET: begin
                AluOperation = ALU_PASS;
                state_d      = ST_FETCH;
            end
            ST_FETCH: state_d = ST_FETCH_WAIT;
            ST_FETCH_WAIT: begin
                LoadIR  = 1'b1;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                // Speculatively compute the branch target while reading registers
                loadRegA      = 1'b1;
                loadRegB      = 1'b1;
                SelMux2       = SRCA_PC;
                SelMux4       = SRCB_SHIFT;
                loadRegAluOut = 1'b1;
                case (iclass_s)
                    IC_R:          state_d = ST_EXEC_R;
                    IC_ADDI:       state_d = ST_EXEC_I;
                    IC_LD, IC_SD:  state_d = ST_ADDR;
                    IC_BEQ, IC_BNE: state_d = ST_BRANCH;
                    IC_LUI:        state_d = ST_WB_LUI;
                    default:       state_d = ST_HALT;
                endcase
            end
            ST_EXEC_R: begin
                SelMux2       = SRCA_REGA;
                SelMux4       = SRCB_REGB;
                AluOperation  = r_alu_op_s;
                loadRegAluOut = 1'b1;
                state_d       = illegal_s ? ST_HALT : ST_WB_ALU;
            end
            ST_EXEC_I, ST_ADDR: begin
                SelMux2       = SRCA_REGA;
                SelMux4       = SRCB_IMM;
                loadRegAluOut = 1'b1;
                if (state_q == ST_EXEC_I) begin
                    state_d = ST_WB_ALU;
                end else if (iclass_s == IC_SD) begin
                    state_d = ST_MEM_WR;
                end else begin
                    state_d = ST_MEM_RD;
                end
            end
            ST_WB_ALU: begin
                RegWrite  = 1'b1;
                SelMuxMem = WB_ALUOUT;
                state_d   = ST_PC_INC;
            end
            ST_MEM_RD: state_d = ST_MEM_WAIT;
            ST_MEM_WAIT: begin
                loadRegMemData = 1'b1;
                state_d        = ST_WB_LD;
            end
            ST_WB_LD: begin
                RegWrite  = 1'b1;
                SelMuxMem = WB_MEMDATA;
                state_d   = ST_PC_INC;
            end
            ST_MEM_WR: begin
                MemData_Read = 1'b1;
                state_d      = ST_PC_INC;
            end
            ST_BRANCH: begin
                // Taken branches load the target from AluOut and skip PC_INC
                taken_s      = ((iclass_s == IC_BEQ) && AluZero) ||
                               ((iclass_s == IC_BNE) && !AluZero);
                SelMux2      = SRCA_REGA;
                SelMux4      = SRCB_REGB;
                AluOperation = ALU_SUB;
                PCWriteCond  = 1'b1;
                SelMuxPC     = PC_ALUOUT;
                PCwrite      = taken_s;
                state_d      = taken_s ? ST_FETCH : ST_PC_INC;
            end
            ST_WB_LUI: begin
                RegWrite  = 1'b1;
                SelMuxMem = WB_IMM;
                state_d   = ST_PC_INC;
            end
            ST_PC_INC: begin
                SelMux2  = SRCA_PC;
                SelMux4  = SRCB_FOUR;
                SelMuxPC = PC_ALU;
                PCwrite  = 1'b1;
                state_d  = ST_FETCH;
            end
            ST_HALT: begin
                halted  = 1'b1;
                state_d = ST_HALT;
            end
            default: state_d = ST_RESET;
        endcase
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Directed bench for controle_multiciclo: a per-cycle table of
// {IR, AluZero, expected state, expected control word} plus halt/reset sequences.
module tb_controle_multiciclo;
    import controle_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  i6_0;
    logic [31:0] i31_0;
    logic        AluZero;
    logic        PCwrite, PCWriteCond, LoadIR, MemRead, MemData_Read, SelMux2;
    logic [1:0]  SelMux4;
    logic [2:0]  SelMuxMem;
    logic        SelMuxPC, RegWrite, loadRegA, loadRegB, loadRegMemData, loadRegAluOut;
    logic [2:0]  AluOperation;
    logic        halted;
    logic [4:0]  state_o;

    controle_multiciclo dut (
        .clk(clk), .rst(rst), .i6_0(i6_0), .i31_0(i31_0), .AluZero(AluZero),
        .PCwrite(PCwrite), .PCWriteCond(PCWriteCond), .LoadIR(LoadIR),
        .MemRead(MemRead), .MemData_Read(MemData_Read), .SelMux2(SelMux2),
        .SelMux4(SelMux4), .SelMuxMem(SelMuxMem), .SelMuxPC(SelMuxPC),
        .RegWrite(RegWrite), .loadRegA(loadRegA), .loadRegB(loadRegB),
        .loadRegMemData(loadRegMemData), .loadRegAluOut(loadRegAluOut),
        .AluOperation(AluOperation), .halted(halted), .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ir;
        logic        zero;
        state_t      st;
        logic [20:0] cw;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    logic [20:0] cw_s;
    assign cw_s = {PCwrite, PCWriteCond, LoadIR, MemRead, MemData_Read, SelMux2,
                   SelMux4, SelMuxMem, SelMuxPC, RegWrite, loadRegA, loadRegB,
                   loadRegMemData, loadRegAluOut, AluOperation, halted};

    function automatic logic [20:0] cw(input logic pcw, input logic pcwc, input logic lir,
                                       input logic mdr, input logic sm2, input logic [1:0] sm4,
                                       input logic [2:0] smm, input logic smpc, input logic rw,
                                       input logic la, input logic lb, input logic lmd,
                                       input logic lao, input logic [2:0] aop, input logic h);
        return {pcw, pcwc, lir, 1'b0, mdr, sm2, sm4, smm, smpc, rw, la, lb, lmd, lao, aop, h};
    endfunction

    function automatic logic [20:0] exr(input logic [2:0] op);
        return cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b000, 1'b0, 1'b0,
                  1'b0, 1'b0, 1'b0, 1'b1, op, 1'b0);
    endfunction

    logic [20:0] cw_reset, cw_fetch, cw_fwait, cw_decode, cw_exi, cw_wbalu, cw_mwait;
    logic [20:0] cw_wbld, cw_memwr, cw_br_t, cw_br_n, cw_wblui, cw_pcinc, cw_halt;

    localparam logic [31:0] IR_ADD  = 32'h002081B3;
    localparam logic [31:0] IR_SUB  = 32'h402081B3;
    localparam logic [31:0] IR_AND  = 32'h0020F1B3;
    localparam logic [31:0] IR_SLT  = 32'h0020A1B3;
    localparam logic [31:0] IR_ADDI = 32'h00500093;
    localparam logic [31:0] IR_LD   = 32'h0080B283;
    localparam logic [31:0] IR_SD   = 32'h0020B823;
    localparam logic [31:0] IR_BEQ  = 32'h00208463;
    localparam logic [31:0] IR_BNE  = 32'h00209463;
    localparam logic [31:0] IR_LUI  = 32'h123450B7;
    localparam logic [31:0] IR_BADO = 32'h0000007F;
    localparam logic [31:0] IR_SLL  = 32'h002091B3;

    task automatic push(input logic [31:0] ir, input logic z, input state_t st, input logic [20:0] c);
        vec_t v;
        v.ir = ir; v.zero = z; v.st = st; v.cw = c;
        vecs.push_back(v);
    endtask

    task automatic prologue(input logic [31:0] ir, input logic z);
        push(ir, z, ST_FETCH,      cw_fetch);
        push(ir, z, ST_FETCH_WAIT, cw_fwait);
        push(ir, z, ST_DECODE,     cw_decode);
    endtask

    task automatic chk(input string name, input int idx, input logic [25:0] act, input logic [25:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got state/ctrl %h, expected %h", name, idx, act, exp);
        end
    endtask

    // One cycle: drive inputs after the falling edge, compare state and controls
    task automatic step(input string name, input int idx, input logic [31:0] ir, input logic z,
                        input state_t st, input logic [20:0] c);
        @(negedge clk);
        i6_0 = ir[6:0]; i31_0 = ir; AluZero = z;
        #1;
        chk(name, idx, {state_o, cw_s}, {st, c});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; i6_0 = 7'd0; i31_0 = 32'd0; AluZero = 1'b0;
        #1;
        chk("reset", 0, {state_o, cw_s}, {ST_RESET, cw_reset});
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; i6_0 = 7'd0; i31_0 = 32'd0; AluZero = 1'b0;

        cw_reset  = cw(0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0);
        cw_fetch  = cw(0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 0, 0, 0, 3'b001, 0);
        cw_fwait  = cw(0, 0, 1, 0, 0, 2'b00, 3'b000, 0, 0, 0, 0, 0, 0, 3'b001, 0);
        cw_decode = cw(0, 0, 0, 0, 0, 2'b11, 3'b000, 0, 0, 1, 1, 0, 1, 3'b001, 0);
        cw_exi    = cw(0, 0, 0, 0, 1, 2'b10, 3'b000, 0, 0, 0, 0, 0, 1, 3'b001, 0);
        cw_wbalu  = cw(0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 1, 0, 0, 0, 0, 3'b001, 0);
        cw_mwait  = cw(0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 0, 1, 0, 3'b001, 0);
        cw_wbld   = cw(0, 0, 0, 0, 0, 2'b00, 3'b001, 0, 1, 0, 0, 0, 0, 3'b001, 0);
        cw_memwr  = cw(0, 0, 0, 1, 0, 2'b00, 3'b000, 0, 0, 0, 0, 0, 0, 3'b001, 0);
        cw_br_t   = cw(1, 1, 0, 0, 1, 2'b00, 3'b000, 1, 0, 0, 0, 0, 0, 3'b010, 0);
        cw_br_n   = cw(0, 1, 0, 0, 1, 2'b00, 3'b000, 1, 0, 0, 0, 0, 0, 3'b010, 0);
        cw_wblui  = cw(0, 0, 0, 0, 0, 2'b00, 3'b010, 0, 1, 0, 0, 0, 0, 3'b001, 0);
        cw_pcinc  = cw(1, 0, 0, 0, 0, 2'b01, 3'b000, 0, 0, 0, 0, 0, 0, 3'b001, 0);
        cw_halt   = cw(0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 0, 0, 0, 3'b001, 1);

        // R-type: add, sub, and, slt (6 cycles each)
        prologue(IR_ADD, 0);  push(IR_ADD, 0, ST_EXEC_R, exr(3'b001));
        push(IR_ADD, 0, ST_WB_ALU, cw_wbalu); push(IR_ADD, 0, ST_PC_INC, cw_pcinc);
        prologue(IR_SUB, 0);  push(IR_SUB, 0, ST_EXEC_R, exr(3'b010));
        push(IR_SUB, 0, ST_WB_ALU, cw_wbalu); push(IR_SUB, 0, ST_PC_INC, cw_pcinc);
        prologue(IR_AND, 0);  push(IR_AND, 0, ST_EXEC_R, exr(3'b011));
        push(IR_AND, 0, ST_WB_ALU, cw_wbalu); push(IR_AND, 0, ST_PC_INC, cw_pcinc);
        prologue(IR_SLT, 0);  push(IR_SLT, 0, ST_EXEC_R, exr(3'b111));
        push(IR_SLT, 0, ST_WB_ALU, cw_wbalu); push(IR_SLT, 0, ST_PC_INC, cw_pcinc);
        // addi (6 cycles)
        prologue(IR_ADDI, 0); push(IR_ADDI, 0, ST_EXEC_I, cw_exi);
        push(IR_ADDI, 0, ST_WB_ALU, cw_wbalu); push(IR_ADDI, 0, ST_PC_INC, cw_pcinc);
        // ld (8 cycles): loadRegMemData in cycle 6, write-back in cycle 7
        prologue(IR_LD, 0);   push(IR_LD, 0, ST_ADDR, cw_exi);
        push(IR_LD, 0, ST_MEM_RD, cw_fetch);  push(IR_LD, 0, ST_MEM_WAIT, cw_mwait);
        push(IR_LD, 0, ST_WB_LD, cw_wbld);    push(IR_LD, 0, ST_PC_INC, cw_pcinc);
        // sd (6 cycles): one write strobe in cycle 5
        prologue(IR_SD, 0);   push(IR_SD, 0, ST_ADDR, cw_exi);
        push(IR_SD, 0, ST_MEM_WR, cw_memwr);  push(IR_SD, 0, ST_PC_INC, cw_pcinc);
        // beq taken (4), beq not taken (5), bne taken (4), bne not taken (5)
        prologue(IR_BEQ, 1);  push(IR_BEQ, 1, ST_BRANCH, cw_br_t);
        prologue(IR_BEQ, 0);  push(IR_BEQ, 0, ST_BRANCH, cw_br_n);
        push(IR_BEQ, 0, ST_PC_INC, cw_pcinc);
        prologue(IR_BNE, 0);  push(IR_BNE, 0, ST_BRANCH, cw_br_t);
        prologue(IR_BNE, 1);  push(IR_BNE, 1, ST_BRANCH, cw_br_n);
        push(IR_BNE, 1, ST_PC_INC, cw_pcinc);
        // lui (5 cycles)
        prologue(IR_LUI, 0);  push(IR_LUI, 0, ST_WB_LUI, cw_wblui);
        push(IR_LUI, 0, ST_PC_INC, cw_pcinc);

        // Power-on reset, then FETCH one cycle after release
        @(negedge clk); @(negedge clk);
        #1;
        chk("reset", 0, {state_o, cw_s}, {ST_RESET, cw_reset});
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step("table", i, vecs[i].ir, vecs[i].zero, vecs[i].st, vecs[i].cw);
        end

        // Illegal opcode halts and stays halted
        step("bad_op", 0, IR_BADO, 0, ST_FETCH, cw_fetch);
        step("bad_op", 1, IR_BADO, 0, ST_FETCH_WAIT, cw_fwait);
        step("bad_op", 2, IR_BADO, 0, ST_DECODE, cw_decode);
        for (int k = 0; k < 20; k++) begin
            step("halt_hold", k, IR_ADD, k[0], ST_HALT, cw_halt);
        end

        // Unsupported R-type function halts out of EXEC_R
        do_reset();
        step("bad_funct", 0, IR_SLL, 0, ST_FETCH, cw_fetch);
        step("bad_funct", 1, IR_SLL, 0, ST_FETCH_WAIT, cw_fwait);
        step("bad_funct", 2, IR_SLL, 0, ST_DECODE, cw_decode);
        @(negedge clk);
        #1;
        chk("bad_funct_exec", 3, {state_o, 21'd0}, {ST_EXEC_R, 21'd0});
        step("bad_funct", 4, IR_SLL, 0, ST_HALT, cw_halt);

        // Reset in the middle of MEM_WR drops the write strobe at once
        do_reset();
        step("rst_memwr", 0, IR_SD, 0, ST_FETCH, cw_fetch);
        step("rst_memwr", 1, IR_SD, 0, ST_FETCH_WAIT, cw_fwait);
        step("rst_memwr", 2, IR_SD, 0, ST_DECODE, cw_decode);
        step("rst_memwr", 3, IR_SD, 0, ST_ADDR, cw_exi);
        step("rst_memwr", 4, IR_SD, 0, ST_MEM_WR, cw_memwr);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async", 5, {state_o, cw_s}, {ST_RESET, cw_reset});
        @(negedge clk);
        rst = 1'b0;
        step("rst_memwr", 6, IR_SD, 0, ST_FETCH, cw_fetch);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/controle_multiciclo.md
# controle_multiciclo

Multicycle control unit for the 64-bit RISC-V datapath (`UP`): a Moore FSM that reads the instruction-register fields and ALU flags and drives every mux select, register load and write strobe of the datapath. It sits directly upstream of the datapath, whose control inputs it feeds one-to-one. It supports add, sub, and, slt, addi, ld, sd, beq, bne and lui. Any other encoding halts the machine until reset.

## Interface
Parameters:
- none; all encodings come from `controle_pkg`

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- i6_0  in  7  opcode from IR
- i31_0  in  32  full IR; funct3 = [14:12], funct7 = [31:25]
- AluZero  in  1  ALU result == 0
- PCwrite  out  1  PC load
- PCWriteCond  out  1  high in BRANCH (observability)
- LoadIR  out  1  IR load
- MemRead  out  1  instruction-memory Wr; tied 0
- MemData_Read  out  1  data-memory Wr; 1 = write
- SelMux2  out  1  ALU A source: 0 = PC, 1 = RegA
- SelMux4  out  2  ALU B source: 00 = RegB, 01 = const 4, 10 = SignExit, 11 = ShiftExit
- SelMuxMem  out  3  register write-back source: 000 = AluOut, 001 = MemDataReg, 010 = SignExit
- SelMuxPC  out  1  PC source: 0 = AluExit, 1 = AluOut_Exit
- RegWrite, loadRegA, loadRegB, loadRegMemData, loadRegAluOut  out  1 each  register loads
- AluOperation  out  3  000 pass A, 001 add, 010 sub, 011 and, 111 set-less-than
- halted  out  1  sticky illegal-instruction flag
- state_o  out  5  current state, debug

## Operation
- Outputs are a pure function of state. The single exception is PCwrite in BRANCH. Every output not listed for a state is 0; default AluOperation is 001.
- RESET: all outputs 0 → FETCH.
- FETCH: instruction memory read at PC → FETCH_WAIT.
- FETCH_WAIT: LoadIR = 1 → DECODE.
- DECODE: loadRegA = loadRegB = 1; SelMux2 = 0, SelMux4 = 11, add, loadRegAluOut = 1 (branch target). Dispatch on opcode:
  - 0110011 → EXEC_R
  - 0010011 with f3 = 000 → EXEC_I
  - 0000011 / 0100011 with f3 = 011 → ADDR
  - 1100011 with f3 = 000/001 → BRANCH
  - 0110111 → WB_LUI
  - anything else → HALT
- EXEC_R: SelMux2 = 1, SelMux4 = 00. AluOperation by function:
  - f7 = 0, f3 = 000 → add
  - f7 = 0100000, f3 = 000 → sub
  - f3 = 111 → and
  - f3 = 010 → 111 (slt)
  - other → HALT instead of WB_ALU
  - loadRegAluOut = 1 → WB_ALU
- EXEC_I: SelMux2 = 1, SelMux4 = 10, add, loadRegAluOut = 1 → WB_ALU.
- WB_ALU: RegWrite = 1, SelMuxMem = 000 → PC_INC.
- ADDR: SelMux2 = 1, SelMux4 = 10, add, loadRegAluOut = 1 → MEM_RD for ld, MEM_WR for sd.
- MEM_RD → MEM_WAIT (loadRegMemData = 1) → WB_LD (RegWrite = 1, SelMuxMem = 001) → PC_INC.
- MEM_WR: MemData_Read = 1 for exactly one cycle → PC_INC.
- BRANCH: SelMux2 = 1, SelMux4 = 00, sub, PCWriteCond = 1, SelMuxPC = 1.
  - Taken = (beq & AluZero) | (bne & ~AluZero).
  - PCwrite = taken.
  - Taken → FETCH; not taken → PC_INC.
- WB_LUI: RegWrite = 1, SelMuxMem = 010 → PC_INC.
- PC_INC: SelMux2 = 0, SelMux4 = 01, add, SelMuxPC = 0, PCwrite = 1 → FETCH.
- HALT: all strobes 0, halted = 1; self-loop until rst.

## Timing
- Cycles per instruction:
  - R / addi / sd: 6
  - ld: 8
  - lui: 5
  - branch taken: 4
  - branch not taken: 5
- rst asserted at any time: state → RESET immediately (asynchronous); outputs 0 within the same cycle; an in-flight MEM_WR strobe is dropped.
- First FETCH occurs on the first clk edge after rst deasserts.
- PC is never written twice in one instruction.
- RegWrite and MemData_Read are each high for at most one cycle per instruction.

## Structure
- `controle_pkg` holds:
  - state enum (RESET, FETCH, FETCH_WAIT, DECODE, EXEC_R, EXEC_I, WB_ALU, ADDR, MEM_RD, MEM_WAIT, WB_LD, MEM_WR, BRANCH, WB_LUI, PC_INC, HALT)
  - opcode/funct constants
  - ALU-op and mux-select encodings
- One sub-module, `decodifica_instr`: combinational opcode/funct3/funct7 → instruction class plus illegal flag, used by DECODE and EXEC_R.

## Test plan
- Reset for 1 cycle → all outputs 0, state_o = RESET; one cycle after release state_o = FETCH.
- IR = 0x002081B3 (add x3,x1,x2) → 6-cycle sequence. EXEC_R drives AluOperation = 001. WB_ALU drives RegWrite = 1 and SelMuxMem = 000. PC_INC drives PCwrite = 1.
- IR = 0x402081B3 (sub) → AluOperation = 010 in EXEC_R. IR = 0x0080B283 (ld x5,8(x1)) → 8 cycles; loadRegMemData = 1 in cycle 6; RegWrite with SelMuxMem = 001 in cycle 7.
- IR = 0x0020B823 (sd x2,16(x1)) → MemData_Read = 1 exactly in cycle 5; RegWrite stays 0 throughout.
- IR = 0x00208463 (beq +8):
  - AluZero = 1 → PCwrite = 1 with SelMuxPC = 1 in cycle 4, next state FETCH.
  - AluZero = 0 → PCwrite = 0 in BRANCH, then PC_INC.
- IR = 0x0000007F → HALT with halted = 1 held for 20 cycles. rst asserted during MEM_WR of a subsequent run → MemData_Read falls immediately.
